// File: rtl/gen_sample_fifo.sv
// gen_sample_fifo: sample buffer between the function generator and its consumer.
// First-word fall-through FIFO with almost-full stall flag and sticky drop flag.
//
// Ports:
//   clk, rst       clock (rising edge), async active-high reset
//   wr_en_i        generator write strobe
//   wr_data_i      sample from generator
//   rd_ready_i     consumer accepts rd_data_o this cycle
//   rd_valid_o     rd_data_o holds the oldest sample
//   rd_data_o      oldest stored sample
//   count_o        stored samples, 0..DEPTH
//   full_o         count_o == DEPTH
//   empty_o        count_o == 0
//   almost_full_o  count_o >= AFULL_THRESH
//   overflow_o     sticky: a write was dropped
//   clr_ovf_i      synchronous clear of overflow_o
module gen_sample_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic                     rd_ready_i,
  output logic                     rd_valid_o,
  output logic [DATA_WIDTH-1:0]    rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     overflow_o,
  input  logic                     clr_ovf_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] AF = CW'(AFULL_THRESH);
  localparam logic [AW:0] ONE = CW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // MSB of each pointer is the wrap bit
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        ovf;

  logic push;
  logic pop;
  logic drop;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                && (wr_ptr[AW] != rd_ptr[AW]);

  assign almost_full_o = (count >= AF);
  assign count_o       = count;
  assign overflow_o    = ovf;
  assign rd_valid_o    = !empty_o;
  assign rd_data_o     = mem[rd_ptr[AW-1:0]];

  // Acceptance uses only the registered full flag: a pop in the
  // same cycle does not make room for the incoming sample.
  assign push = wr_en_i && !full_o;
  assign drop = wr_en_i && full_o;
  assign pop  = rd_ready_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      // a drop in the same cycle as a clear keeps the flag set
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf_i) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gen_sample_fifo.sv
// tb_gen_sample_fifo: directed and random checks of gen_sample_fifo
// against a queue-based reference model.
module tb_gen_sample_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [4:0]    count;
  logic          full;
  logic          empty;
  logic          afull;
  logic          ovf;
  logic          clr_ovf;

  gen_sample_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .AFULL_THRESH(AFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en_i(wr_en),
    .wr_data_i(wr_data),
    .rd_ready_i(rd_ready),
    .rd_valid_o(rd_valid),
    .rd_data_o(rd_data),
    .count_o(count),
    .full_o(full),
    .empty_o(empty),
    .almost_full_o(afull),
    .overflow_o(ovf),
    .clr_ovf_i(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  logic          m_ovf;
  int            vec;
  int            miss;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, "_count"}, 32'(count), 32'(n));
    chk({tag, "_empty"}, 32'(empty), 32'(n == 0));
    chk({tag, "_full"},  32'(full),  32'(n == DEPTH));
    chk({tag, "_afull"}, 32'(afull), 32'(n >= AFT));
    chk({tag, "_valid"}, 32'(rd_valid), 32'(n != 0));
    chk({tag, "_ovf"},   32'(ovf),   32'(m_ovf));
    if (n != 0) begin
      chk({tag, "_data"}, 32'(rd_data), 32'(q[0]));
    end
  endtask

  // one clock: drive inputs, update model from pre-edge state, check
  task automatic step(input string tag, input logic wr,
                      input logic [DW-1:0] d, input logic rdy,
                      input logic clr);
    bit do_push;
    bit do_pop;
    bit do_drop;
    wr_en    = wr;
    wr_data  = d;
    rd_ready = rdy;
    clr_ovf  = clr;
    @(posedge clk);
    do_push = wr && (q.size() < DEPTH);
    do_drop = wr && (q.size() == DEPTH);
    do_pop  = rdy && (q.size() > 0);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
    if (do_drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    check_all(tag);
  endtask

  initial begin
    vec      = 0;
    miss     = 0;
    m_ovf    = 1'b0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // mid-stream async reset with five entries stored
    for (int i = 0; i < 5; i++) begin
      step("fill5", 1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
    end
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_all("mid_rst");
    #1 rst = 1'b0;

    // three pushes held, then popped in order
    for (int i = 1; i <= 3; i++) begin
      step("hold", 1'b1, DW'(i), 1'b0, 1'b0);
    end
    step("hold_wait", 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("pop3", 1'b0, '0, 1'b1, 1'b0);
    end
    chk("pop3_empty", 32'(empty), 32'd1);

    // fill to full, then a dropped 0x7FFF
    for (int i = 1; i <= 16; i++) begin
      step("fill16", 1'b1, DW'(i), 1'b0, 1'b0);
    end
    chk("fill16_full", 32'(full), 32'd1);
    step("drop", 1'b1, 16'h7FFF, 1'b0, 1'b0);
    chk("drop_ovf", 32'(ovf), 32'd1);

    // full with write and pop together: pop happens, write dropped
    step("full_wr_rd", 1'b1, 16'h7FFE, 1'b1, 1'b0);
    chk("full_wr_rd_cnt", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++) begin
      step("drain", 1'b0, '0, 1'b1, 1'b0);
    end
    step("clr", 1'b0, '0, 1'b0, 1'b1);

    // steady push+pop across two wraps
    for (int i = 0; i < 3; i++) begin
      step("pre", 1'b1, DW'(16'h0A00 + i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      step("steady", 1'b1, DW'($urandom), 1'b1, 1'b0);
    end
    chk("steady_cnt", 32'(count), 32'd3);
    chk("steady_ovf", 32'(ovf), 32'd0);

    // clear collides with drop: set wins; clear alone then clears
    for (int i = 0; i < 13; i++) begin
      step("refill", 1'b1, DW'($urandom), 1'b0, 1'b0);
    end
    step("drop_clr", 1'b1, 16'h1234, 1'b0, 1'b1);
    chk("drop_clr_ovf", 32'(ovf), 32'd1);
    step("clr_only", 1'b0, '0, 1'b0, 1'b1);
    chk("clr_only_ovf", 32'(ovf), 32'd0);

    // random traffic: write-heavy, then read-heavy
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = (i < 300) ? 70 : 35;
      step("rand",
           1'($urandom_range(0, 99) < wp),
           DW'($urandom),
           1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
